// File: rtl/user_axil_resp.sv
// AXI-Lite style register slave: RW register file, write counter and ID word.
// Writes have no response channel; reads return data through a two-state FSM.
module user_axil_resp #(
    parameter int                     pADDR_WIDTH = 12,
    parameter int                     pDATA_WIDTH = 32,
    parameter int                     pNUM_REGS   = 16,
    parameter logic [pDATA_WIDTH-1:0] pID         = 32'h5553_0001
) (
    input  logic                             axi_clk,
    input  logic                             axi_reset,
    input  logic                             awvalid,
    input  logic [pADDR_WIDTH-1:0]           awaddr,
    output logic                             awready,
    input  logic                             wvalid,
    input  logic [3:0]                       wstrb,
    input  logic [pDATA_WIDTH-1:0]           wdata,
    output logic                             wready,
    input  logic                             arvalid,
    input  logic [pADDR_WIDTH-1:0]           araddr,
    output logic                             arready,
    output logic                             rvalid,
    output logic [pDATA_WIDTH-1:0]           rdata,
    input  logic                             rready,
    output logic [pNUM_REGS*pDATA_WIDTH-1:0] reg_q
);

    localparam logic [9:0] IDX_WCNT = 10'h3FE;
    localparam logic [9:0] IDX_ID   = 10'h3FF;

    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic                   aw_full;
    logic                   w_full;
    logic [9:0]             aw_idx;
    logic [pDATA_WIDTH-1:0] w_data;
    logic [3:0]             w_strb;
    logic [pDATA_WIDTH-1:0] wcnt;
    logic [pDATA_WIDTH-1:0] regs [pNUM_REGS];
    logic [pDATA_WIDTH-1:0] rd_src;
    logic [9:0]             ar_idx;
    rstate_t                state;
    rstate_t                state_next;
    logic                   unused_bits;

    assign unused_bits = ^{awaddr[1:0], araddr[1:0]};

    // Ready flags come straight from the holding flops.
    assign awready = !aw_full;
    assign wready  = !w_full;

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            wcnt    <= '0;
            for (int i = 0; i < pNUM_REGS; i++) regs[i] <= '0;
        end else if (aw_full && w_full) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            wcnt    <= wcnt + 1'b1;
            for (int i = 0; i < pNUM_REGS; i++) begin
                if (aw_idx == i[9:0]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end else begin
            if (awvalid && !aw_full) begin
                aw_full <= 1'b1;
                aw_idx  <= awaddr[11:2];
            end
            if (wvalid && !w_full) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
        end
    end

    for (genvar g = 0; g < pNUM_REGS; g++) begin : g_regq
        assign reg_q[g*pDATA_WIDTH +: pDATA_WIDTH] = regs[g];
    end

    assign ar_idx = araddr[11:2];

    always_comb begin
        rd_src = '0;
        for (int i = 0; i < pNUM_REGS; i++) begin
            if (ar_idx == i[9:0]) rd_src = regs[i];
        end
        if (ar_idx == IDX_WCNT) rd_src = wcnt;
        if (ar_idx == IDX_ID)   rd_src = pID;
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) state <= R_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            R_IDLE: if (arvalid) state_next = R_DATA;
            R_DATA: if (rready)  state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (state == R_IDLE);
        rvalid  = (state == R_DATA);
    end

    // Data is zero whenever rvalid is low so read buses can be OR-combined.
    always_ff @(posedge axi_clk) begin
        if (axi_reset)                       rdata <= '0;
        else if (state == R_IDLE && arvalid) rdata <= rd_src;
        else if (state == R_DATA && rready)  rdata <= '0;
    end

endmodule

// File: tb/tb_user_axil_resp.sv
// Bench for user_axil_resp: directed steps plus randomized traffic
// compared against a word-level model of the register map.
module tb_user_axil_resp;

    localparam int          NR = 16;
    localparam int          PW = NR * 32;
    localparam logic [31:0] ID = 32'h5553_0001;

    logic          clk = 1'b0;
    logic          axi_reset;
    logic          awvalid;
    logic [11:0]   awaddr;
    logic          awready;
    logic          wvalid;
    logic [3:0]    wstrb;
    logic [31:0]   wdata;
    logic          wready;
    logic          arvalid;
    logic [11:0]   araddr;
    logic          arready;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          rready;
    logic [PW-1:0] reg_q;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] m_regs [NR];
    logic [31:0] m_wcnt;

    always #5 clk = ~clk;

    user_axil_resp dut (
        .axi_clk  (clk),
        .axi_reset(axi_reset),
        .awvalid  (awvalid),
        .awaddr   (awaddr),
        .awready  (awready),
        .wvalid   (wvalid),
        .wstrb    (wstrb),
        .wdata    (wdata),
        .wready   (wready),
        .arvalid  (arvalid),
        .araddr   (araddr),
        .arready  (arready),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .rready   (rready),
        .reg_q    (reg_q)
    );

    task automatic check(input string tag, input logic [PW-1:0] obs,
                         input logic [PW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_wcnt = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int idx = int'(a[11:2]);
        if (idx < NR)     return m_regs[idx];
        if (idx == 'h3FE) return m_wcnt;
        if (idx == 'h3FF) return ID;
        return 32'h0;
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        int          idx = int'(a[11:2]);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s[b]}};
        if (idx < NR) m_regs[idx] = (m_regs[idx] & ~mask) | (d & mask);
        m_wcnt = m_wcnt + 32'd1;
    endtask

    function automatic logic [PW-1:0] model_regq();
        logic [PW-1:0] v;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = m_regs[i];
        return v;
    endfunction

    // da/dw: cycle offsets of the address and data valids.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int da, input int dw);
        int n = (da > dw) ? da : dw;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("awready_wait", awready, (k <= da));
                check("wready_wait", wready, (k <= dw));
            end
            awvalid = (k == da);
            wvalid  = (k == dw);
            awaddr  = a;
            wdata   = d;
            wstrb   = s;
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("awready_full", awready, 0);
        check("wready_full", wready, 0);
        check("regq_before_commit", reg_q, model_regq());
        model_write(a, d, s);
        @(negedge clk);
        check("awready_after", awready, 1);
        check("wready_after", wready, 1);
        check("regq_after_commit", reg_q, model_regq());
    endtask

    task automatic do_read(input logic [11:0] a, input int hold);
        logic [31:0] exp = model_read(a);
        @(negedge clk);
        check("arready_idle", arready, 1);
        arvalid = 1'b1;
        araddr  = a;
        rready  = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid", rvalid, 1);
        check("rdata", rdata, exp);
        check("arready_busy", arready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, exp);
            check("arready_hold", arready, 0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_done", rvalid, 0);
        check("rdata_zero", rdata, 0);
        check("arready_done", arready, 1);
    endtask

    function automatic logic [11:0] rand_addr();
        int          r  = int'($urandom_range(0, 19));
        logic [9:0]  idx;
        logic [1:0]  lo = 2'($urandom);
        if (r < NR)       idx = 10'(r);
        else if (r == 16) idx = 10'd16;
        else if (r == 17) idx = 10'h3FE;
        else if (r == 18) idx = 10'h3FF;
        else              idx = 10'h200;
        return {idx, lo};
    endfunction

    initial begin
        logic [31:0] old;
        axi_reset = 1'b1;
        awvalid = 0; awaddr = 0; wvalid = 0; wstrb = 0; wdata = 0;
        arvalid = 0; araddr = 0; rready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        axi_reset = 1'b0;
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_arready", arready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_regq", reg_q, 0);

        do_write(12'h004, 32'hDEAD_BEEF, 4'hF, 0, 0);
        check("reg1_deadbeef", reg_q[63:32], 32'hDEAD_BEEF);
        do_read(12'h004, 0);
        do_read(12'hFF8, 0);

        do_write(12'h000, 32'h1122_3344, 4'h5, 3, 0);
        check("reg0_partial", reg_q[31:0], 32'h0022_0044);

        do_read(12'hFFC, 5);

        do_write(12'h040, 32'h1234_5678, 4'hF, 0, 0);
        do_write(12'hFFC, 32'h8765_4321, 4'hF, 1, 0);
        do_read(12'h040, 0);
        do_read(12'hFF8, 1);

        do_write(12'h008, 32'h0F0F_1234, 4'hF, 0, 2);
        @(negedge clk);
        awvalid = 1; awaddr = 12'h008;
        wvalid = 1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        arvalid = 1; araddr = 12'h008; rready = 0;
        old = model_read(12'h008);
        model_write(12'h008, 32'hA5A5_A5A5, 4'hF);
        @(negedge clk);
        arvalid = 0;
        check("collide_rvalid", rvalid, 1);
        check("collide_old", rdata, old);
        check("collide_regq", reg_q, model_regq());
        rready = 1;
        @(negedge clk);
        rready = 0;
        check("collide_done", rvalid, 0);
        do_read(12'h008, 0);

        @(negedge clk);
        force dut.wcnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.wcnt;
        m_wcnt = 32'hFFFF_FFFF;
        do_read(12'hFF8, 0);
        do_write(12'h00C, 32'h0000_0001, 4'h1, 0, 0);
        do_read(12'hFF8, 0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0)
                do_write(rand_addr(), $urandom, 4'($urandom),
                         int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)));
            else
                do_read(rand_addr(), int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        awvalid = 1; awaddr = 12'h00C;
        @(negedge clk);
        awvalid = 0;
        check("mid_aw_held", awready, 0);
        axi_reset = 1;
        wvalid = 1; wdata = 32'h5555_AAAA; wstrb = 4'hF;
        @(negedge clk);
        axi_reset = 0;
        wvalid = 0;
        model_reset();
        check("mid_rst_awready", awready, 1);
        check("mid_rst_wready", wready, 1);
        check("mid_rst_regq", reg_q, 0);
        @(negedge clk);
        wvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        @(negedge clk);
        wvalid = 0;
        check("mid_w_full", wready, 0);
        check("mid_aw_free", awready, 1);
        @(negedge clk);
        check("mid_w_waiting", wready, 0);
        check("mid_no_commit", reg_q, 0);
        do_read(12'hFF8, 0);

        axi_reset = 1;
        @(negedge clk);
        axi_reset = 0;
        check("final_wready", wready, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
